// File: rtl/moore_fsm_pkg.sv
// Shared constants and state type for the 4-4-2-8 digit sequence detector.
package moore_fsm_pkg;

  localparam int N = 4;

  localparam logic [N-1:0] SEQ0 = 4'd4;
  localparam logic [N-1:0] SEQ1 = 4'd4;
  localparam logic [N-1:0] SEQ2 = 4'd2;
  localparam logic [N-1:0] SEQ3 = 4'd8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DET  = 3'd5
  } state_t;

endpackage

// File: rtl/moore_fsm_if.sv
// Groups the detector's control, digit and flag signals for bench-side wiring.
interface moore_fsm_if;
  import moore_fsm_pkg::*;

  logic         start;
  logic [N-1:0] digit_in;
  logic         sequence_detected;

  modport master (
    output start,
    output digit_in,
    input  sequence_detected
  );

  modport slave (
    input  start,
    input  digit_in,
    output sequence_detected
  );

endinterface

// File: rtl/moore_fsm.sv
// Moore FSM detecting digit sequence 4,4,2,8 with overlap.
// The flag decodes the registered state only.
module moore_fsm
  import moore_fsm_pkg::*;
(
  input  logic         clk,
  input  logic         asyn_n_rst,
  input  logic         start,
  input  logic [N-1:0] digit_in,
  output logic         sequence_detected
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (asyn_n_rst) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // start re-arms from any armed state before digits are considered
  always_comb begin
    w_next = IDLE;
    unique case (r_state)
      IDLE: w_next = start ? S0 : IDLE;
      S0: begin
        if (start)                 w_next = S0;
        else if (digit_in == SEQ0) w_next = S1;
        else                       w_next = S0;
      end
      S1: begin
        if (start)                 w_next = S0;
        else if (digit_in == SEQ1) w_next = S2;
        else                       w_next = S0;
      end
      S2: begin
        if (start)                 w_next = S0;
        else if (digit_in == SEQ2) w_next = S3;
        else if (digit_in == SEQ1) w_next = S2;
        else                       w_next = S0;
      end
      S3: begin
        if (start)                 w_next = S0;
        else if (digit_in == SEQ3) w_next = DET;
        else if (digit_in == SEQ0) w_next = S1;
        else                       w_next = S0;
      end
      DET: begin
        if (start)                 w_next = S0;
        else if (digit_in == SEQ0) w_next = S1;
        else                       w_next = S0;
      end
      default: w_next = IDLE;
    endcase
  end

  assign sequence_detected = (r_state == DET);

endmodule

// File: tb/tb_moore_fsm.sv
// Scoreboard bench for moore_fsm: directed digit vectors,
// expected flag and state queued by the driver, checked by a monitor.
module tb_moore_fsm;
  import moore_fsm_pkg::*;

  typedef struct {
    logic   det;
    logic   chk;
    state_t st;
    int     id;
  } exp_t;

  logic clk;
  logic asyn_n_rst;
  int   checks;
  int   errors;
  int   vec;
  exp_t q[$];

  moore_fsm_if bus();

  moore_fsm dut (
    .clk               (clk),
    .asyn_n_rst        (asyn_n_rst),
    .start             (bus.start),
    .digit_in          (bus.digit_in),
    .sequence_detected (bus.sequence_detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input logic         r,
    input logic         s,
    input logic [N-1:0] d,
    input logic         e,
    input logic         c,
    input state_t       st
  );
    exp_t x;
    @(negedge clk);
    asyn_n_rst   = r;
    bus.start    = s;
    bus.digit_in = d;
    x.det = e;
    x.chk = c;
    x.st  = st;
    x.id  = vec;
    q.push_back(x);
    vec++;
  endtask

  task automatic dig(input logic [N-1:0] d, input logic e, input state_t st);
    step(1'b0, 1'b0, d, e, 1'b1, st);
  endtask

  task automatic rst1();
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, IDLE);
  endtask

  task automatic arm();
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b1, S0);
  endtask

  // Monitor: one output per clock, compared just after the edge
  initial begin
    exp_t x;
    state_t got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        checks++;
        if (bus.sequence_detected !== x.det) begin
          errors++;
          $display("FAIL det vec=%0d got=%b exp=%b",
                   x.id, bus.sequence_detected, x.det);
        end
        if (x.chk) begin
          checks++;
          got = dut.r_state;
          if (got !== x.st) begin
            errors++;
            $display("FAIL state vec=%0d got=%s exp=%s",
                     x.id, got.name(), x.st.name());
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    vec    = 0;
    asyn_n_rst   = 1'b1;
    bus.start    = 1'b0;
    bus.digit_in = '0;

    // Detection after noise digits and an extra 4
    rst1();
    arm();
    dig(4'd0, 1'b0, S0);
    dig(4'd0, 1'b0, S0);
    dig(4'd3, 1'b0, S0);
    dig(4'd4, 1'b0, S1);
    dig(4'd4, 1'b0, S2);
    dig(4'd4, 1'b0, S2);
    dig(4'd2, 1'b0, S3);
    dig(4'd8, 1'b1, DET);
    dig(4'd0, 1'b0, S0);

    // Not armed: digits ignored
    rst1();
    dig(4'd4, 1'b0, IDLE);
    dig(4'd4, 1'b0, IDLE);
    dig(4'd2, 1'b0, IDLE);
    dig(4'd8, 1'b0, IDLE);

    // Back-to-back sequences: two pulses four cycles apart
    rst1();
    arm();
    dig(4'd4, 1'b0, S1);
    dig(4'd4, 1'b0, S2);
    dig(4'd2, 1'b0, S3);
    dig(4'd8, 1'b1, DET);
    dig(4'd4, 1'b0, S1);
    dig(4'd4, 1'b0, S2);
    dig(4'd2, 1'b0, S3);
    dig(4'd8, 1'b1, DET);
    dig(4'd5, 1'b0, S0);

    // Reset mid-sequence discards the partial match
    rst1();
    arm();
    dig(4'd4, 1'b0, S1);
    dig(4'd4, 1'b0, S2);
    dig(4'd2, 1'b0, S3);
    step(1'b1, 1'b1, 4'd8, 1'b0, 1'b1, IDLE);
    dig(4'd8, 1'b0, IDLE);

    // start beats a matching 8
    arm();
    dig(4'd4, 1'b0, S1);
    dig(4'd4, 1'b0, S2);
    dig(4'd2, 1'b0, S3);
    step(1'b0, 1'b1, 4'd8, 1'b0, 1'b1, S0);
    dig(4'd8, 1'b0, S0);

    // Broken sequences, including out-of-range digits
    dig(4'd4, 1'b0, S1);
    dig(4'd4, 1'b0, S2);
    dig(4'd2, 1'b0, S3);
    dig(4'd7, 1'b0, S0);
    dig(4'd8, 1'b0, S0);
    dig(4'd4, 1'b0, S1);
    dig(4'd4, 1'b0, S2);
    dig(4'd9, 1'b0, S0);
    dig(4'd2, 1'b0, S0);
    dig(4'd8, 1'b0, S0);
    dig(4'd15, 1'b0, S0);

    // S3 on 4 restarts at S1; DET with start re-arms; never back to IDLE
    dig(4'd4, 1'b0, S1);
    dig(4'd4, 1'b0, S2);
    dig(4'd2, 1'b0, S3);
    dig(4'd4, 1'b0, S1);
    dig(4'd4, 1'b0, S2);
    dig(4'd2, 1'b0, S3);
    dig(4'd8, 1'b1, DET);
    step(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, S0);
    dig(4'd12, 1'b0, S0);

    @(negedge clk);
    bus.start    = 1'b0;
    bus.digit_in = '0;
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/moore_fsm.md
MOORE_FSM -- requirements
Module: moore_fsm

Interface
REQ-001 The module SHALL use these ports, clock and reset first:
- clk  input  1  single system clock; all state changes on its rising edge.
- asyn_n_rst  input  1  reset; synchronous and active-high (port name retained as in the codebase; it is neither asynchronous nor active-low).
- start  input  1  arms detection; sampled on clk rising edge.
- digit_in  input  N  one decimal digit per cycle, unsigned, N=4 from moore_fsm_pkg.
- sequence_detected  output  1  high while the FSM is in state DET.

REQ-002 Package parameter: N = 4, digit width in bits.
REQ-003 Package parameters: SEQ0=4'd4, SEQ1=4'd4, SEQ2=4'd2, SEQ3=4'd8; the target sequence is 4,4,2,8 in that order.

Function
REQ-004 The module SHALL be a Moore FSM with states IDLE, S0, S1, S2, S3 and DET.
REQ-005 State meanings SHALL be: S0 armed with no match; S1 "4" matched; S2 "44" matched; S3 "442" matched; DET full sequence matched.
REQ-006 sequence_detected SHALL be a function of the registered state only, 1 in DET and 0 in every other state, with no combinational path from digit_in or start.
REQ-007 In IDLE, start=1 SHALL cause IDLE->S0; start=0 SHALL hold IDLE, and digit_in SHALL be ignored.
REQ-008 In any armed state (S0..DET), start=1 SHALL force the next state to S0 regardless of digit_in; start has priority over digit matching.
REQ-009 With start=0, the next state SHALL be evaluated against the digit_in value sampled on the same edge, as follows:
- S0: 4->S1; any other digit->S0.
- S1: 4->S2; any other digit->S0.
- S2: 2->S3; 4->S2 (overlap, last two digits still "44"); any other digit->S0.
- S3: 8->DET; 4->S1; any other digit->S0.
- DET: 4->S1; any other digit->S0.
REQ-010 Overlapping detection SHALL be supported per REQ-009; consecutive sequences (4,4,2,8,4,4,2,8) SHALL produce two detection pulses.
REQ-011 Latency: if the final 8 is sampled on edge k, sequence_detected SHALL be 1 from edge k until edge k+1 (one cycle), then follow the next state.
REQ-012 The FSM SHALL never return to IDLE except by reset; after a detection it stays armed.
REQ-013 Digit values 9..15 SHALL be treated as non-matching digits and never cause an error state.
REQ-014 All state encodings not listed in REQ-004 SHALL transition to IDLE on the next edge.

Reset
REQ-015 When asyn_n_rst=1 at a clk rising edge, the state SHALL become IDLE and sequence_detected SHALL be 0 from that edge.
REQ-016 Reset SHALL take priority over start and digit_in, including mid-sequence; any partial match is discarded.
REQ-017 Before the first reset edge, output values are undefined and the bench SHALL not check them.

Structure
REQ-018 Package moore_fsm_pkg SHALL contain N, SEQ0..SEQ3 and the state enum typedef (IDLE, S0, S1, S2, S3, DET).
REQ-019 The module SHALL be a single module with a state register, next-state logic and output decode, and no sub-modules.

Verification
REQ-020 Reset then start=1 for one cycle, then digits 0,0,3,4,4,4,2,8 -> sequence_detected=1 for exactly one cycle, the cycle after 8 is sampled; 0 elsewhere.
REQ-021 No start pulse, then digits 4,4,2,8 -> sequence_detected stays 0 and the state stays IDLE.
REQ-022 Armed, then 4,4,2,8,4,4,2,8 -> two one-cycle pulses four cycles apart.
REQ-023 Armed, then 4,4,2, then reset asserted for one edge, then 8 -> no pulse; state IDLE.
REQ-024 Armed, then 4,4,2, then start=1 with digit_in=8 -> no pulse; state S0.
REQ-025 Armed, then 4,4,2,7,8 and 4,4,9,2,8 -> no pulse in either case.
